// File: rtl/two_to_four_grant_decoder.sv
// Timed 2:4 grant decoder: turns an encoded winner index into a one-hot grant
// held for HOLD_CYCLES, followed by a GAP_CYCLES guard gap with all lines low.
module two_to_four_grant_decoder #(
  parameter int HOLD_CYCLES = 4,  // 1..15
  parameter int GAP_CYCLES  = 1   // 0..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in1,
  input  logic       in0,
  input  logic       in_none,
  output logic       out3,
  output logic       out2,
  output logic       out1,
  output logic       out0,
  output logic       out_valid,
  output logic       err,
  output logic [7:0] grant_cnt
);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [3:0]  grant_reg, grant_next;
  logic        valid_reg, valid_next;
  logic        err_reg, err_next;
  logic [7:0]  grant_cnt_reg, grant_cnt_next;
  logic [3:0]  dec;
  logic        accept;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dec
      assign dec[gi] = ({in1, in0} == 2'(gi));
    end
  endgenerate

  assign in_ready = (state_reg == IDLE);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    grant_next     = grant_reg;
    valid_next     = valid_reg;
    err_next       = 1'b0;
    grant_cnt_next = grant_cnt_reg;
    case (state_reg)
      IDLE: begin
        grant_next = 4'b0000;
        valid_next = 1'b0;
        if (accept) begin
          if (in_none) begin
            err_next = 1'b1;
          end else begin
            state_next     = HOLD;
            cnt_next       = 4'(HOLD_CYCLES - 1);
            grant_next     = dec;
            valid_next     = 1'b1;
            grant_cnt_next = grant_cnt_reg + 8'd1;
          end
        end
      end
      HOLD: begin
        if (cnt_reg == 4'd0) begin
          grant_next = 4'b0000;
          valid_next = 1'b0;
          if (GAP_CYCLES > 0) begin
            state_next = GAP;
            cnt_next   = 4'(GAP_CYCLES - 1);
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      GAP: begin
        if (cnt_reg == 4'd0) state_next = IDLE;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      default: begin
        state_next = IDLE;
        grant_next = 4'b0000;
        valid_next = 1'b0;
      end
    endcase
  end

  // Asynchronous clear so grant lines drop the instant rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      grant_reg     <= 4'b0000;
      valid_reg     <= 1'b0;
      err_reg       <= 1'b0;
      grant_cnt_reg <= 8'd0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      grant_reg     <= grant_next;
      valid_reg     <= valid_next;
      err_reg       <= err_next;
      grant_cnt_reg <= grant_cnt_next;
    end
  end

  assign {out3, out2, out1, out0} = grant_reg;
  assign out_valid = valid_reg;
  assign err       = err_reg;
  assign grant_cnt = grant_cnt_reg;

endmodule
